// File: rtl/core_inst_sequencer.sv
// ---------------------------------------------------------------------------
// core_inst_sequencer
//
// Turns one `start` pulse into the complete instruction stream for a
// convolution run. For every kernel index (kij) it steps through weight fetch
// (xmem -> L0), kernel load into the PE array, activation fetch (xmem -> L0),
// execute, and output-FIFO drain into psum SRAM. After the last kij it pulses
// `done` and returns to idle.
//
// Ports
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high reset
//   start        in   1   one-cycle run request, honoured only while idle
//   ofifo_valid  in   1   core output FIFO holds a full row
//   inst         out  34  registered instruction word to the core
//   busy         out  1   run in progress (registered)
//   done         out  1   one-cycle end-of-run pulse (registered)
//
// inst layout: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] pmem addr,
// [19] CEN_xmem, [18] WEN_xmem, [17:7] xmem addr, [6] ofifo_rd, [5] ififo_wr,
// [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
//
// Every output is a register fed from the decode of the current state, so
// the whole instruction stream trails the internal state by exactly one cycle.
// ---------------------------------------------------------------------------
module core_inst_sequencer #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int KIJ_NUM = 9,
    parameter int NIJ_LEN = 36,
    parameter int W_BASE  = 1024,
    parameter int X_BASE  = 0,
    parameter int P_BASE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    localparam int PW = 16;  // phase / drain counter width
    localparam int KW = 8;   // kij counter width

    localparam logic [PW-1:0] ROW_C  = PW'(ROW);
    localparam logic [PW-1:0] COL_C  = PW'(COL);
    localparam logic [PW-1:0] NIJ_C  = PW'(NIJ_LEN);
    localparam logic [KW-1:0] KIJ_LAST = KW'(KIJ_NUM - 1);

    // CEN/WEN deasserted for both SRAMs, everything else quiet.
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FETCH,
        S_K_LOAD,
        S_X_FETCH,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] pmem_addr;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] xmem_addr;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;     // cycle index inside the current phase
    logic [KW-1:0]  kij_q, kij_d;
    logic [PW-1:0]  rd_cnt_q, rd_cnt_d;   // ofifo reads issued in this DRAIN
    logic [PW-1:0]  wr_cnt_q, wr_cnt_d;   // pmem writes issued in this DRAIN
    logic           wr_pend_q, wr_pend_d; // a read was issued last cycle
    inst_t          inst_d;
    logic [33:0]    inst_q;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [10:0]    w_addr, x_addr, p_addr;

    // 11-bit address arithmetic; the casts make the modulo-2048 wrap explicit.
    assign w_addr = 11'(W_BASE + int'(kij_q) * COL + int'(phase_q));
    assign x_addr = 11'(X_BASE + int'(phase_q));
    assign p_addr = 11'(P_BASE + int'(kij_q) * NIJ_LEN + int'(wr_cnt_q));

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        kij_d     = kij_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_pend_d = 1'b0;
        inst_d    = inst_t'(IDLE_WORD);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W_FETCH;
                    phase_d = '0;
                    kij_d   = '0;
                end
            end

            // row reads, each followed one cycle later by an L0 write to
            // cover the SRAM read latency: row+1 cycles in total.
            S_W_FETCH: begin
                if (phase_q < ROW_C) begin
                    inst_d.cen_xmem  = 1'b0;
                    inst_d.xmem_addr = w_addr;
                end
                if (phase_q != '0) begin
                    inst_d.l0_wr = 1'b1;
                end
                if (phase_q == ROW_C) begin
                    state_d = S_K_LOAD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            // col load cycles, then one idle bubble.
            S_K_LOAD: begin
                if (phase_q < COL_C) begin
                    inst_d.l0_rd = 1'b1;
                    inst_d.load  = 1'b1;
                end
                if (phase_q == COL_C) begin
                    state_d = S_X_FETCH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_X_FETCH: begin
                if (phase_q < NIJ_C) begin
                    inst_d.cen_xmem  = 1'b0;
                    inst_d.xmem_addr = x_addr;
                end
                if (phase_q != '0) begin
                    inst_d.l0_wr = 1'b1;
                end
                if (phase_q == NIJ_C) begin
                    state_d = S_EXEC;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_EXEC: begin
                inst_d.l0_rd   = 1'b1;
                inst_d.execute = 1'b1;
                if (phase_q == NIJ_C - 1'b1) begin
                    state_d  = S_DRAIN;
                    phase_d  = '0;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            // A read in one cycle produces the pmem write in the next; the two
            // overlap when rows stream back to back. Stalls indefinitely while
            // ofifo_valid is low.
            S_DRAIN: begin
                if (ofifo_valid && (rd_cnt_q < NIJ_C)) begin
                    inst_d.ofifo_rd = 1'b1;
                    rd_cnt_d        = rd_cnt_q + 1'b1;
                    wr_pend_d       = 1'b1;
                end
                if (wr_pend_q) begin
                    inst_d.cen_pmem  = 1'b0;
                    inst_d.wen_pmem  = 1'b0;
                    inst_d.pmem_addr = p_addr;
                    wr_cnt_d         = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == NIJ_C - 1'b1) begin
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                        phase_d  = '0;
                        if (kij_q == KIJ_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            kij_d   = kij_q + 1'b1;
                            state_d = S_W_FETCH;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_d = (state_q == S_DONE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    // NOTE: reset clears every flop here, including the pending-write flag, so
    // an interrupted drain cannot emit a stray pmem write afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            kij_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            inst_q    <= IDLE_WORD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            kij_q     <= kij_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_inst_sequencer
//
// Directed bench for core_inst_sequencer with default parameters. A table of
// hand-computed instruction words at known cycle offsets after `start` covers
// the free-running run; hand-written sequences cover the drain stall, reset
// mid-EXEC, an ignored start and a toggling ofifo_valid.
//
// Offset k is the k-th sample after the edge that accepts `start`; the word
// sampled at k = 0 is the first weight read. One kij takes 128 cycles with
// ofifo_valid held high, and `done` is seen at k = 9*128 = 1152.
// ---------------------------------------------------------------------------
module tb_core_inst_sequencer;

    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
    localparam logic [6:0]  C_NONE = 7'h00;
    localparam logic [6:0]  C_L0W  = 7'h04;  // l0_wr
    localparam logic [6:0]  C_LOAD = 7'h09;  // l0_rd | load
    localparam logic [6:0]  C_EXEC = 7'h0A;  // l0_rd | execute
    localparam logic [6:0]  C_ORD  = 7'h40;  // ofifo_rd

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        int          k;
        logic [33:0] inst;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[$];

    core_inst_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Build an instruction word from its fields on top of the idle word.
    function automatic logic [33:0] word(input bit xr, input int xa, input bit pw,
                                         input int pa, input logic [6:0] ctl);
        logic [33:0] r;
        r = IDLE_W;
        if (xr) begin
            r[19]    = 1'b0;
            r[17:7]  = 11'(xa);
        end
        if (pw) begin
            r[32]    = 1'b0;
            r[31]    = 1'b0;
            r[30:20] = 11'(pa);
        end
        r[6:0] = ctl;
        return r;
    endfunction

    function automatic void add(input string name, input int k, input logic [33:0] w,
                                input logic b, input logic d);
        vec_t v;
        v.name = name; v.k = k; v.inst = w; v.busy = b; v.done = d;
        tbl.push_back(v);
    endfunction

    // ofifo_valid seen by state cycle j. Mode 0: always high; 1: low for 20
    // cycles inside kij 0 DRAIN (which starts at j = 91); 2: alternating.
    function automatic logic valid_for(input int mode, input int j);
        if (mode == 1) return !(j >= 96 && j <= 115);
        if (mode == 2) return (j % 2) == 0;
        return 1'b1;
    endfunction

    // One run. ign_k: state cycle that sees a stray start (-1 for none).
    // abort_k: sample after which reset is pulsed and the run abandoned.
    task automatic run(input int mode, input int ign_k, input int abort_k,
                       input int exp_done_k, input int limit);
        int  n_wr     = 0;
        int  n_rd     = 0;
        int  done_cnt = 0;
        int  done_k   = -1;
        bit  prev_rd  = 1'b0;
        bit  bad_fix  = 1'b0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        ofifo_valid = valid_for(mode, 0);

        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            // every pmem write must follow a read and land on the next address
            if (inst[32] == 1'b0) begin
                check("write_follows_read", 64'(prev_rd), 64'd1);
                check("pmem_addr_contig", 64'(inst[30:20]), 64'(11'(n_wr)));
                check("wen_pmem_low", 64'(inst[31]), 64'd0);
                n_wr++;
            end
            prev_rd = inst[6];
            if (inst[6]) n_rd++;
            if (inst[33] || inst[5] || inst[4] || !inst[18]) bad_fix = 1'b1;
            if (done) begin
                done_cnt++;
                done_k = k;
            end

            if (mode == 0) begin
                foreach (tbl[i]) begin
                    if (tbl[i].k == k) begin
                        check({tbl[i].name, "_inst"}, 64'(inst), 64'(tbl[i].inst));
                        check({tbl[i].name, "_busy"}, 64'(busy), 64'(tbl[i].busy));
                        check({tbl[i].name, "_done"}, 64'(done), 64'(tbl[i].done));
                    end
                end
            end
            if (mode == 1 && k >= 96 && k <= 115) begin
                check("stall_no_ofifo_rd", 64'(inst[6]), 64'd0);
                if (k >= 97) check("stall_idle_word", 64'(inst), 64'(IDLE_W));
            end

            if (k == abort_k) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("abort_inst_idle", 64'(inst), 64'(IDLE_W));
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                return;
            end

            start       = (k + 1 == ign_k);
            ofifo_valid = valid_for(mode, k + 1);
            if (done_k >= 0 && k == done_k + 1) break;
        end

        check("done_pulse_count", 64'(done_cnt), 64'd1);
        if (exp_done_k >= 0) check("done_cycle", 64'(done_k), 64'(exp_done_k));
        check("pmem_write_total", 64'(n_wr), 64'd324);
        check("ofifo_read_total", 64'(n_rd), 64'd324);
        check("fixed_bits_ok", 64'(bad_fix), 64'd0);
    endtask

    initial begin
        // kij 0 weight fetch, load, activation fetch, execute, drain
        add("w_rd_first",  0,    word(1, 1024, 0, 0, C_NONE), 1, 0);
        add("w_rd_1",      1,    word(1, 1025, 0, 0, C_L0W),  1, 0);
        add("w_rd_last",   7,    word(1, 1031, 0, 0, C_L0W),  1, 0);
        add("w_l0w_tail",  8,    word(0, 0, 0, 0, C_L0W),     1, 0);
        add("load_first",  9,    word(0, 0, 0, 0, C_LOAD),    1, 0);
        add("load_last",   16,   word(0, 0, 0, 0, C_LOAD),    1, 0);
        add("load_bubble", 17,   IDLE_W,                      1, 0);
        add("x_rd_first",  18,   word(1, 0, 0, 0, C_NONE),    1, 0);
        add("x_rd_1",      19,   word(1, 1, 0, 0, C_L0W),     1, 0);
        add("x_rd_last",   53,   word(1, 35, 0, 0, C_L0W),    1, 0);
        add("x_l0w_tail",  54,   word(0, 0, 0, 0, C_L0W),     1, 0);
        add("exec_first",  55,   word(0, 0, 0, 0, C_EXEC),    1, 0);
        add("exec_last",   90,   word(0, 0, 0, 0, C_EXEC),    1, 0);
        add("drain_rd0",   91,   word(0, 0, 0, 0, C_ORD),     1, 0);
        add("drain_wr0",   92,   word(0, 0, 1, 0, C_ORD),     1, 0);
        add("drain_wr34",  126,  word(0, 0, 1, 34, C_ORD),    1, 0);
        add("drain_wr35",  127,  word(0, 0, 1, 35, C_NONE),   1, 0);
        add("kij1_w_rd",   128,  word(1, 1032, 0, 0, C_NONE), 1, 0);
        // kij 8
        add("kij8_w_rd0",  1024, word(1, 1088, 0, 0, C_NONE), 1, 0);
        add("kij8_w_rd7",  1031, word(1, 1095, 0, 0, C_L0W),  1, 0);
        add("kij8_wr0",    1116, word(0, 0, 1, 288, C_ORD),   1, 0);
        add("kij8_wr35",   1151, word(0, 0, 1, 323, C_NONE),  1, 0);
        add("done_pulse",  1152, IDLE_W,                      0, 1);
        add("after_done",  1153, IDLE_W,                      0, 0);

        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_inst", 64'(inst), 64'(IDLE_W));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        // start together with reset: reset wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("start_under_reset_busy", 64'(busy), 64'd0);
        check("start_under_reset_inst", 64'(inst), 64'(IDLE_W));

        // full run with ofifo_valid tied high
        run(0, -1, -1, 1152, 2000);
        // drain stall of 20 cycles in kij 0
        run(1, -1, -1, 1172, 2000);
        // reset in kij 3 EXEC (state cycles 439..474), then a clean rerun
        run(0, -1, 3 * 128 + 60, -1, 2000);
        repeat (2) @(negedge clk);
        check("post_abort_idle", 64'(inst), 64'(IDLE_W));
        run(0, -1, -1, 1152, 2000);
        // stray start during X_FETCH of kij 0
        run(0, 30, -1, 1152, 2000);
        // alternating ofifo_valid
        run(2, -1, -1, -1, 4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
